// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: C-priority arbiter for the shared MMU data port (ports C/D in, dm_* out to MMU, dm_do back), with a D wait counter and locked D bursts
module dm_port_arbiter #(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [3:0]  c_be,
  input  logic        c_signed,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  input  logic        d_signed,
  input  logic        d_last,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_di,
  output logic [3:0]  dm_be,
  output logic        dm_we,
  output logic        dm_signed,
  input  logic [31:0] dm_do
);
  typedef enum logic {NORM, DLOCK} state_t;
  localparam logic [2:0] WMAX = 3'(MAX_WAIT);
  localparam logic [3:0] BMAX = 4'(BURST_MAX);
  state_t state, state_n;
  logic [2:0] wait_cnt, wait_n;
  logic [3:0] beat_cnt, beat_n;
  logic rv_c, rv_d;
  always_comb begin
    d_gnt = !reset && d_req && (state == DLOCK || wait_cnt == WMAX || !c_req);
    c_gnt = !reset && c_req && state == NORM && !d_gnt;
    state_n = state;
    beat_n = beat_cnt;
    if (state == NORM) begin
      if (d_gnt && !d_last && BMAX > 4'd1) begin
        state_n = DLOCK;
        beat_n = 4'd1;
      end
    end else if (!d_req) begin
      state_n = NORM;
    end else begin
      beat_n = beat_cnt + 4'd1;
      state_n = (d_last || beat_n == BMAX) ? NORM : DLOCK;
    end
    wait_n = (state == DLOCK || d_gnt || !d_req) ? 3'd0 :
             (wait_cnt == WMAX) ? wait_cnt : wait_cnt + 3'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= NORM;
      wait_cnt <= 3'd0;
      beat_cnt <= 4'd0;
      rv_c <= 1'b0;
      rv_d <= 1'b0;
    end else begin
      state <= state_n;
      wait_cnt <= wait_n;
      beat_cnt <= beat_n;
      rv_c <= c_gnt;
      rv_d <= d_gnt;
    end
  end
  assign dm_addr   = c_gnt ? c_addr   : d_gnt ? d_addr   : '0;
  assign dm_di     = c_gnt ? c_wdata  : d_gnt ? d_wdata  : '0;
  assign dm_be     = c_gnt ? c_be     : d_gnt ? d_be     : '0;
  assign dm_we     = c_gnt ? c_we     : d_gnt && d_we;
  assign dm_signed = c_gnt ? c_signed : d_gnt && d_signed;
  assign c_rvalid  = rv_c && !reset;
  assign d_rvalid  = rv_d && !reset;
  assign c_rdata   = c_rvalid ? dm_do : '0;
  assign d_rdata   = d_rvalid ? dm_do : '0;
endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single MMU data-memory port between two requesters: the CPU load/store unit (port C) and a debug/DMA engine (port D).
- Arbitration is fixed-priority to C. A wait counter guarantees D forward progress, and an optional locked burst gives D exclusive access.
- The MMU has one-clock access latency. The arbiter issues at most one access per cycle and routes each returned word to its owner.
- It sits directly in front of the MMU data-port inputs (dm_addr/dm_di/dm_be/dm_we/is_signed) and output (dm_do).

Parameters:
- MAX_WAIT, 4, consecutive cycles D may be denied before it is forced to win arbitration (1..7).
- BURST_MAX, 4, maximum granted beats in one locked D burst (1..15).

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- c_req  input  1  CPU access request.
- c_we  input  1  CPU write enable.
- c_addr  input  32  CPU byte address.
- c_wdata  input  32  CPU write data, right-justified.
- c_be  input  4  CPU byte enable, non-encoded.
- c_signed  input  1  CPU load sign-extend.
- c_gnt  output  1  CPU request accepted this cycle (combinational).
- c_rvalid  output  1  CPU response valid (registered).
- c_rdata  output  32  CPU read data.
- d_req, d_we, d_addr[31:0], d_wdata[31:0], d_be[3:0], d_signed  input  D equivalents of the C inputs.
- d_last  input  1  D beat is the final beat of its burst.
- d_gnt  output  1  D request accepted this cycle (combinational).
- d_rvalid  output  1  D response valid (registered).
- d_rdata  output  32  D read data.
- dm_addr  output  32  to MMU.
- dm_di  output  32  to MMU.
- dm_be  output  4  to MMU.
- dm_we  output  1  to MMU.
- dm_signed  output  1  to MMU is_signed.
- dm_do  input  32  from MMU, valid one cycle after issue.

Behaviour:
- Issue path: MMU inputs are muxed from the granted port in the same cycle. With no grant, dm_be=0, dm_we=0, dm_signed=0 and dm_addr/dm_di=0, so no RAM bank is enabled and nothing is written.
- Exactly one of c_gnt/d_gnt is high at a time. A grant requires the matching req.
- Response path: owner flags rv_c/rv_d register c_gnt/d_gnt. c_rvalid=rv_c, d_rvalid=rv_d. c_rdata=dm_do when c_rvalid, else 0; d_rdata likewise.
- Responses are produced for writes too; requesters ignore the data.
- Back-to-back issue is supported: a new grant in cycle N+1 coexists with the response for cycle N.
- FSM states:
  - NORM:
    - If wait_cnt==MAX_WAIT and d_req, grant D. Otherwise, if c_req, grant C. Otherwise, if d_req, grant D.
    - If D is granted with d_last=0, go to DLOCK with beat_cnt=1.
  - DLOCK (C never granted):
    - d_gnt=d_req. Each D grant increments beat_cnt.
    - Return to NORM after a granted beat with d_last=1, or after the granted beat where beat_cnt reaches BURST_MAX (forced release).
    - Return to NORM on any cycle with d_req=0, so an idle D cannot hang the port.
- wait_cnt (3 bits):
  - Cleared when d_gnt=1 or d_req=0.
  - Otherwise incremented, saturating at MAX_WAIT.
  - Held at 0 in DLOCK.
- Simultaneous c_req and d_req in NORM with wait_cnt<MAX_WAIT: C wins.
- A C request arriving during DLOCK waits. C has no starvation counter; bursts are bounded by BURST_MAX.
- Reset:
  - While reset=1, c_gnt=d_gnt=0 and MMU outputs are idle as above.
  - On the clock edge: state=NORM, wait_cnt=0, beat_cnt=0, rv_c=rv_d=0.
  - Reset mid-burst or with a response in flight drops that response: no rvalid is produced the following cycle.
- Requester inputs are sampled only in the grant cycle. A requester holds its req and payload until granted.

Test Plan:
- Reset, then C reads at 0x10000004 with c_be=1111 after the word was written to 0x12345678 → c_gnt in cycle 0; dm_be=1111 in cycle 0; c_rvalid=1 with c_rdata=0x12345678 in cycle 1; d_rvalid=0.
- c_req and d_req both held high, d_last=1 → C granted 4 consecutive cycles, D granted in cycle 5 (wait_cnt==4), then C again; no cycle has both grants.
- Idle (no req) with stale dm_do → dm_be=0000 and dm_we=0; c_rvalid=d_rvalid=0; no RAM contents change.
- D burst of 3 beats (d_last on beat 3) with c_req held → d_gnt for 3 cycles, c_gnt=0 throughout, C granted in cycle 4; d_rvalid follows each beat by one cycle.
- D burst with d_last never asserted, BURST_MAX=4 → lock released after the 4th beat; C granted the next cycle.
- D granted in cycle N, reset asserted in cycle N+1 → d_rvalid=0 in N+1; state NORM and wait_cnt=0 after reset deasserts.
